// File: rtl/srt_radix4_div_iter.sv
// Iterative radix-4 SRT mantissa divider: one signed quotient digit per cycle,
// on-the-fly Q/QM accumulation, final sign correction and sticky generation.

// On-the-fly converter slice: builds either Q (MINUS=0) or QM = Q - ulp (MINUS=1)
// from the current Q/QM pair and the selected digit.
module srt_on_the_fly #(
  parameter int QW    = 26,
  parameter bit MINUS = 1'b0
) (
  input  logic [QW-1:0] q_acc,
  input  logic [QW-1:0] qm_acc,
  input  logic [2:0]    q_t,
  output logic [QW-1:0] next_acc,
  output logic          bad_quotient_digit
);

  // Append the digit to Q or QM so no carry propagation is ever needed.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    next_acc           = q_acc;
    bad_quotient_digit = 1'b0;
    case (q_t)
      3'b010:  next_acc = MINUS ? {q_acc[QW-3:0], 2'b01}  : {q_acc[QW-3:0], 2'b10};
      3'b001:  next_acc = MINUS ? {q_acc[QW-3:0], 2'b00}  : {q_acc[QW-3:0], 2'b01};
      3'b000:  next_acc = MINUS ? {qm_acc[QW-3:0], 2'b11} : {q_acc[QW-3:0], 2'b00};
      3'b111:  next_acc = MINUS ? {qm_acc[QW-3:0], 2'b10} : {qm_acc[QW-3:0], 2'b11};
      3'b110:  next_acc = MINUS ? {qm_acc[QW-3:0], 2'b01} : {qm_acc[QW-3:0], 2'b10};
      default: bad_quotient_digit = 1'b1;
    endcase
  end

endmodule

module srt_radix4_div_iter #(
  parameter int WIDTH  = 24,
  parameter int DIGITS = (WIDTH + 3) / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  output logic                  ready,
  input  logic [WIDTH-1:0]      dividend,
  input  logic [WIDTH-1:0]      divisor,
  output logic                  done,
  output logic [2*DIGITS-1:0]   quotient,
  output logic                  sticky
);

  localparam int QW    = 2 * DIGITS;
  localparam int REM_W = WIDTH + 5;
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;
  typedef enum logic [2:0] {
    ZERO    = 3'b000,
    POS_ONE = 3'b001,
    POS_TWO = 3'b010,
    NEG_TWO = 3'b110,
    NEG_ONE = 3'b111
  } digit_t;

  state_t state, state_next;

  // Remainder and divisor share a 4.(WIDTH+1) two's complement format.
  logic signed [REM_W-1:0] w_reg, d_reg;
  logic signed [REM_W-1:0] s, half_d, three_half_d, w_next, rem_final;
  logic [QW-1:0]           q_reg, qm_reg, next_q, next_qm;
  logic [CNT_W-1:0]        cnt;
  digit_t                  q_t;
  logic                    bad_q, bad_qm, bad_quotient_digit;
  logic                    correct_en;

  assign ready      = (state == IDLE);
  assign correct_en = (state == FINAL) && w_reg[REM_W-1];
  assign rem_final  = correct_en ? (w_reg + d_reg) : w_reg;

  assign s            = w_reg <<< 2;
  assign half_d       = d_reg >>> 1;
  assign three_half_d = d_reg + half_d;

  // Exact full-width digit selection and the matching remainder update.
  always_comb begin
    q_t    = ZERO;
    w_next = s;
    if (s >= three_half_d) begin
      q_t    = POS_TWO;
      w_next = s - (d_reg <<< 1);
    end else if (s >= half_d) begin
      q_t    = POS_ONE;
      w_next = s - d_reg;
    end else if (s > -half_d) begin
      q_t    = ZERO;
      w_next = s;
    end else if (s > -three_half_d) begin
      q_t    = NEG_ONE;
      w_next = s + d_reg;
    end else begin
      q_t    = NEG_TWO;
      w_next = s + (d_reg <<< 1);
    end
  end

  srt_on_the_fly #(.QW(QW), .MINUS(1'b0)) u_otf_q (
    .q_acc              (q_reg),
    .qm_acc             (qm_reg),
    .q_t                (q_t),
    .next_acc           (next_q),
    .bad_quotient_digit (bad_q)
  );

  srt_on_the_fly #(.QW(QW), .MINUS(1'b1)) u_otf_qm (
    .q_acc              (q_reg),
    .qm_acc             (qm_reg),
    .q_t                (q_t),
    .next_acc           (next_qm),
    .bad_quotient_digit (bad_qm)
  );

  assign bad_quotient_digit = bad_q | bad_qm;

  // State register; flush behaves exactly like reset and wins over start.
  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) state <= IDLE;
    else              state <= state_next;
  end

  // Next-state logic: IDLE -> ITER for DIGITS cycles -> FINAL -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ITER;
      ITER:    if (cnt == CNT_W'(DIGITS - 1)) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, per-digit iteration, final correction and done pulse.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w_reg    <= '0;
      d_reg    <= '0;
      q_reg    <= '0;
      qm_reg   <= '0;
      cnt      <= '0;
      quotient <= '0;
      sticky   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_reg  <= {{5{1'b0}}, dividend};
            d_reg  <= {3'b000, divisor, 2'b00};
            q_reg  <= '0;
            qm_reg <= '0;
            cnt    <= '0;
          end
        end
        ITER: begin
          assert (!bad_quotient_digit);
          w_reg  <= w_next;
          q_reg  <= next_q;
          qm_reg <= next_qm;
          cnt    <= cnt + 1'b1;
        end
        FINAL: begin
          quotient <= correct_en ? qm_reg : q_reg;
          sticky   <= (rem_final != '0);
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_radix4_div_iter.sv
// Self-checking bench for srt_radix4_div_iter: directed vectors, latency, flush,
// busy-start rejection, back-to-back and randomized operands against a scoreboard.
module tb_srt_radix4_div_iter;

  localparam int WIDTH  = 24;
  localparam int DIGITS = 13;
  localparam int QW     = 26;

  logic              clk = 1'b0;
  logic              rst, flush, start;
  logic [WIDTH-1:0]  dividend, divisor;
  logic              ready, done, sticky;
  logic [QW-1:0]     quotient;

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;
  int issued     = 0;
  bit bad_seen   = 1'b0;
  bit neg_seen   = 1'b0;

  // Expected {quotient, sticky}, pushed at issue time, popped on done.
  logic [QW:0] sb[$];
  logic [QW:0] mon_exp;

  srt_radix4_div_iter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .ready    (ready),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (done),
    .quotient (quotient),
    .sticky   (sticky)
  );

  always #5 clk = ~clk;

  // Reference: floor(x * 2^(QW-2) / d) and nonzero-remainder flag.
  function automatic logic [QW:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d);
    longint unsigned num, qq, rr;
    num = 64'(x) << (QW - 2);
    qq  = num / 64'(d);
    rr  = num % 64'(d);
    return {qq[QW-1:0], (rr != 0)};
  endfunction

  // Scoreboard monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (dut.bad_quotient_digit && !ready) bad_seen = 1'b1;
    if (dut.correct_en) neg_seen = 1'b1;
    if (!rst && done === 1'b1) begin
      done_count++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: quotient=%h sticky=%b with no operation pending", quotient, sticky);
      end else begin
        mon_exp = sb.pop_front();
        if ({quotient, sticky} !== mon_exp) begin
          n_fail++;
          $display("FAIL result[%0d]: got quotient=%h sticky=%b, required quotient=%h sticky=%b",
                   done_count, quotient, sticky, mon_exp[QW:1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d, input logic [QW:0] exp);
    @(negedge clk);
    assert (x[WIDTH-1] && d[WIDTH-1]) else $fatal(1, "operand not normalized");
    dividend = x;
    divisor  = d;
    start    = 1'b1;
    sb.push_back(exp);
    issued++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; optionally pulse start with junk while busy.
  task automatic wait_done(input string name, input bit poke, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (poke && done !== 1'b1) begin
        start    = ($urandom_range(0, 2) == 0);
        dividend = WIDTH'($urandom());
        divisor  = WIDTH'($urandom());
      end
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required within 40", name, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks += 4;
    if (ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: got %b, required 1", ready); end
    if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    if (quotient !== '0)  begin n_fail++; $display("FAIL reset_quotient: got %h, required 0", quotient); end
    if (sticky !== 1'b0)  begin n_fail++; $display("FAIL reset_sticky: got %b, required 0", sticky); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] xs [4] = '{24'h800000, 24'hC00000, 24'h800000, 24'hFFFFFF};
    logic [WIDTH-1:0] ds [4] = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000};
    logic [QW-1:0]    qs [4] = '{26'h1000000, 26'h1800000, 26'h0AAAAAA, 26'h1FFFFFE};
    logic             ss [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(xs[i], ds[i], {qs[i], ss[i]});
      if (i == 0) begin
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_drop: got %b, required 0", ready); end
      end
      wait_done("directed", 1'b0, cyc);
      if (i == 0) begin
        n_checks++;
        if (cyc != DIGITS + 1) begin
          n_fail++;
          $display("FAIL latency: done %0d edges after accept, required %0d", cyc, DIGITS + 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    int base;
    issue(24'h800000, 24'hC00000, model(24'h800000, 24'hC00000));
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    start    = 1'b1;
    dividend = 24'hC00000;
    divisor  = 24'h800000;
    @(posedge clk);
    #1 flush = 1'b0;
    start = 1'b0;
    void'(sb.pop_back());
    issued--;
    base = done_count;
    n_checks += 4;
    if (ready !== 1'b1)  begin n_fail++; $display("FAIL flush_ready: got %b, required 1", ready); end
    if (done !== 1'b0)   begin n_fail++; $display("FAIL flush_done: got %b, required 0", done); end
    if (quotient !== '0) begin n_fail++; $display("FAIL flush_quotient: got %h, required 0", quotient); end
    if (sticky !== 1'b0) begin n_fail++; $display("FAIL flush_sticky: got %b, required 0", sticky); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (done_count != base) begin
      n_fail++;
      $display("FAIL flush_no_done: got %0d done pulses, required 0", done_count - base);
    end
    issue(24'hA00000, 24'hE00000, model(24'hA00000, 24'hE00000));
    wait_done("after_flush", 1'b0, base);
  endtask

  task automatic test_busy_start();
    int cyc;
    int base;
    logic [QW:0] exp_a;
    exp_a = model(24'hC00000, 24'h900000);
    issue(24'hC00000, 24'h900000, exp_a);
    wait_done("busy_a", 1'b0, cyc);
    base = done_count;
    issue(24'h800000, 24'hFFFFFF, model(24'h800000, 24'hFFFFFF));
    repeat (2) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 24'hFFFFFF;
    divisor  = 24'h800000;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    n_checks += 2;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b, required 0", ready); end
    if (quotient !== exp_a[QW:1]) begin
      n_fail++;
      $display("FAIL quotient_hold: got %h, required %h", quotient, exp_a[QW:1]);
    end
    wait_done("busy_b", 1'b0, cyc);
    @(negedge clk);
    n_checks++;
    if (done_count != base + 1) begin
      n_fail++;
      $display("FAIL busy_done_count: got %0d, required %0d", done_count - base, 1);
    end
  endtask

  // Random operands issued back-to-back in each done cycle, with junk starts while busy.
  task automatic test_back_to_back_random();
    int cyc;
    logic [WIDTH-1:0] x, d;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       begin x = 24'h800000; d = 24'hFFFFFF; end
        1:       begin x = 24'h800000 | WIDTH'($urandom() & 32'h007F_FFFF); d = x; end
        default: begin
          x = 24'h800000 | WIDTH'($urandom() & 32'h007F_FFFF);
          d = 24'h800000 | WIDTH'($urandom() & 32'h007F_FFFF);
        end
      endcase
      issue(x, d, model(x, d));
      if (i > 0 && i % 500 == 0) begin
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready=%b, required 0", ready); end
      end
      wait_done("random", 1'b1, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_invariants();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (bad_seen)             begin n_fail++; $display("FAIL bad_digit: seen=1, required 0"); end
    if (!neg_seen)            begin n_fail++; $display("FAIL neg_correction: seen=0, required 1"); end
    if (done_count != issued) begin n_fail++; $display("FAIL done_total: got %0d, required %0d", done_count, issued); end
    if (sb.size() != 0)       begin n_fail++; $display("FAIL scoreboard_left: got %0d, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_busy_start();
    test_back_to_back_random();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
